// File: rtl/uart_rx_pkg.sv
// Shared UART receive definitions: state encoding, default frame geometry
// and the width helpers used to size the receiver's counters.
package uart_rx_pkg;

  localparam int unsigned NB_STATES   = 3;
  localparam int unsigned DEF_N_DATA  = 8;
  localparam int unsigned DEF_N_TICKS = 16;

  typedef enum logic [NB_STATES-1:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) res = 32'(i + 1);
    end
    return res;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to idle (1).
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta <= 1'b1;
      o_q  <= 1'b1;
    end else begin
      meta <= i_d;
      o_q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start, N_DATA bits LSB first, optional parity, stop.
// Define UART_RX_INPUT_SYNC_EN to pass i_rx through a 2-flop synchroniser first.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned N_DATA       = DEF_N_DATA,
  parameter int unsigned PARITY_CHECK = 0,
  parameter int unsigned N_TICKS      = DEF_N_TICKS,
  parameter int unsigned N_STOP_TICKS = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_tick,
  input  logic                           i_rx,
  output logic [N_DATA+PARITY_CHECK-1:0] o_rx_data,
  output logic                           o_rx_done,
  output logic                           o_frame_err
);

  localparam int unsigned NB_WORD = N_DATA + PARITY_CHECK;
  localparam int unsigned NB_TICK = max2(1, clog2(max2(N_TICKS, N_STOP_TICKS)));
  localparam int unsigned NB_BIT  = max2(1, clog2(N_DATA));

  rx_state_e          state;
  rx_state_e          state_next;
  logic               rx;
  logic [NB_TICK-1:0] s;
  logic [NB_BIT-1:0]  n;
  logic [NB_WORD-1:0] shift;

  logic s_half_c, s_bit_c, s_stop_c, n_last_c;
  logic s_clr_c, s_inc_c, n_clr_c, n_inc_c, shift_c, done_c;

`ifdef UART_RX_INPUT_SYNC_EN
  uart_rx_sync u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx)
  );
`else
  assign rx = i_rx;
`endif

  // Tick-qualified counter terminal conditions.
  assign s_half_c = i_tick && (s == NB_TICK'(N_TICKS / 2 - 1));
  assign s_bit_c  = i_tick && (s == NB_TICK'(N_TICKS - 1));
  assign s_stop_c = i_tick && (s == NB_TICK'(N_STOP_TICKS - 1));
  assign n_last_c = (n == NB_BIT'(N_DATA - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= RX_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:   if (!rx) state_next = RX_START;
      RX_START:  if (s_half_c) state_next = rx ? RX_IDLE : RX_DATA;
      RX_DATA:   if (s_bit_c && n_last_c)
                   state_next = (PARITY_CHECK != 0) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (s_bit_c) state_next = RX_STOP;
      RX_STOP:   if (s_stop_c) state_next = RX_IDLE;
      default:   state_next = RX_IDLE;
    endcase
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    s_clr_c = 1'b0;
    s_inc_c = 1'b0;
    n_clr_c = 1'b0;
    n_inc_c = 1'b0;
    shift_c = 1'b0;
    done_c  = 1'b0;
    case (state)
      RX_IDLE: s_clr_c = !rx;
      RX_START: begin
        if (s_half_c) begin
          s_clr_c = 1'b1;
          n_clr_c = 1'b1;
        end else begin
          s_inc_c = i_tick;
        end
      end
      RX_DATA: begin
        if (s_bit_c) begin
          s_clr_c = 1'b1;
          shift_c = 1'b1;
          n_inc_c = !n_last_c;
        end else begin
          s_inc_c = i_tick;
        end
      end
      RX_PARITY: begin
        if (s_bit_c) begin
          s_clr_c = 1'b1;
          shift_c = 1'b1;
        end else begin
          s_inc_c = i_tick;
        end
      end
      RX_STOP: begin
        if (s_stop_c) begin
          s_clr_c = 1'b1;
          done_c  = 1'b1;
        end else begin
          s_inc_c = i_tick;
        end
      end
      default: s_clr_c = 1'b1;
    endcase
  end

  // The parity bit shares the shift register, so it lands at the word MSB.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s           <= '0;
      n           <= '0;
      shift       <= '0;
      o_rx_data   <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done <= done_c;
      if (s_clr_c)      s <= '0;
      else if (s_inc_c) s <= s + NB_TICK'(1);
      if (n_clr_c)      n <= '0;
      else if (n_inc_c) n <= n + NB_BIT'(1);
      if (shift_c)
        shift <= (shift >> 1) | (NB_WORD'(rx) << (NB_WORD - 1));
      if (done_c) begin
        o_rx_data   <= shift;
        o_frame_err <= ~rx;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random frames into two receivers (no parity / parity),
// compared against an expected-frame queue built from the frame contents.
module tb_uart_rx;

  localparam int BIT_CLKS  = 64;  // 16 ticks per bit, one tick every 4 clocks
  localparam int WAIT_MAX  = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick = 1'b0;
  logic       rx;
  logic [7:0] data;
  logic       done;
  logic       ferr;
  logic [8:0] pdata;
  logic       pdone;
  logic       pferr;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int pdone_cnt = 0;
  int exp_total = 0;
  logic       done_prev = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];

  uart_rx #(.N_DATA(8), .PARITY_CHECK(0), .N_TICKS(16), .N_STOP_TICKS(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx),
    .o_rx_data(data), .o_rx_done(done), .o_frame_err(ferr)
  );

  uart_rx #(.N_DATA(8), .PARITY_CHECK(1), .N_TICKS(16), .N_STOP_TICKS(16)) dut_par (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_rx(rx),
    .o_rx_data(pdata), .o_rx_done(pdone), .o_frame_err(pferr)
  );

  always #5 clk = ~clk;

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tc = (tc + 1) % 4;
      tick = (tc == 0);
    end
  end

  // Capture every completed frame and require single-cycle done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        got_q.push_back({ferr, data});
        done_cnt++;
        checks++;
        assert (done_prev === 1'b0) else begin
          errors++;
          $error("FAIL done_pulse_width: observed=1 expected=0 (done high two clocks)");
        end
      end
      if (pdone === 1'b1) pdone_cnt++;
      done_prev = done;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [9:0] bits, input int nb, input logic stop_bit);
    hold(1'b0, BIT_CLKS);
    for (int i = 0; i < nb; i++) hold(bits[i], BIT_CLKS);
    // A low stop bit is cut short so a re-armed start sees the line high at mid-bit.
    hold(stop_bit, stop_bit ? BIT_CLKS : 40);
    rx = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] b, input logic fe);
    exp_q.push_back({fe, b});
    exp_total++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    push_exp(b, ~stop_bit);
    send_bits(10'(b), 8, stop_bit);
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_pframes(input int target);
    int n;
    n = 0;
    while (pdone_cnt < target && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check("pframe_timeout", 32'(pdone_cnt >= target), 32'd1);
  endtask

  task automatic drain(input string tag);
    logic [8:0] e;
    logic [8:0] g;
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      last_data = e[7:0];
      check({tag, "_data"}, 32'(g[7:0]), 32'(e[7:0]));
      check({tag, "_ferr"}, 32'(g[8]), 32'(e[8]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int cnt0;
    int pcnt0;
    logic [7:0] b;
    logic st;

    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_data", 32'(data), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_ferr", 32'(ferr), 32'h0);
    check("reset_pdata", 32'(pdata), 32'h0);
    rst = 1'b1;
    hold(1'b1, 2 * BIT_CLKS);

    send_byte(8'h55, 1'b1);
    wait_frames(exp_total);
    drain("f55");
    hold(1'b1, BIT_CLKS);

    send_byte(8'hA3, 1'b0);
    wait_frames(exp_total);
    drain("fA3");
    hold(1'b1, 2 * BIT_CLKS);

    // Start-bit glitch of 5 ticks must be rejected.
    cnt0 = done_cnt;
    hold(1'b0, 20);
    hold(1'b1, 3 * BIT_CLKS);
    check("glitch_no_done", 32'(done_cnt), 32'(cnt0));
    check("glitch_data_held", 32'(data), 32'(last_data));

    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h80, 1'b1);
    wait_frames(exp_total);
    drain("b2b");
    hold(1'b1, 2 * BIT_CLKS);

    for (int k = 0; k < 6; k++) begin
      b  = 8'($urandom);
      st = ($urandom_range(0, 3) != 0);
      send_byte(b, st);
      wait_frames(exp_total);
      drain("rand");
      hold(1'b1, st ? int'($urandom_range(0, 1)) * BIT_CLKS : 2 * BIT_CLKS);
    end
    hold(1'b1, 2 * BIT_CLKS);

    // Reset in the middle of data bit 3 of 0x3C aborts the frame.
    cnt0 = done_cnt;
    hold(1'b0, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b0, BIT_CLKS);
    hold(1'b1, BIT_CLKS);
    hold(1'b1, 20);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_ferr", 32'(ferr), 32'h0);
    check("midrst_pdata", 32'(pdata), 32'h0);
    check("midrst_pdone", 32'(pdone), 32'h0);
    check("midrst_pferr", 32'(pferr), 32'h0);
    repeat (3) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b1;
    hold(1'b1, 2 * BIT_CLKS);
    check("midrst_no_done", 32'(done_cnt), 32'(cnt0));

    pcnt0 = pdone_cnt;
    send_byte(8'h42, 1'b1);
    wait_frames(exp_total);
    drain("f42");
    // The parity receiver reads the stop bit of 0x42 as its parity bit.
    wait_pframes(pcnt0 + 1);
    check("par_42_data", 32'(pdata), 32'h142);
    check("par_42_ferr", 32'(pferr), 32'h0);
    hold(1'b1, 2 * BIT_CLKS);

    // Nine-bit frame: 0x0F with parity bit 1.
    pcnt0 = pdone_cnt;
    push_exp(8'h0F, 1'b0);
    send_bits(10'h10F, 9, 1'b1);
    wait_frames(exp_total);
    drain("f0F_nopar");
    wait_pframes(pcnt0 + 1);
    check("par_10F_data", 32'(pdata), 32'h10F);
    check("par_10F_ferr", 32'(pferr), 32'h0);
    hold(1'b1, 2 * BIT_CLKS);

    // Line held low: a zero frame with framing error.
    cnt0 = done_cnt;
    push_exp(8'h00, 1'b1);
    rx = 1'b0;
    wait_frames(exp_total);
    drain("held_low");
    repeat (2) @(negedge clk);
    hold(1'b1, 3 * BIT_CLKS);
    check("held_low_single", 32'(done_cnt), 32'(cnt0 + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; sits directly upstream of the UART/ALU interface FIFO.
- Oversamples the serial line with an external x16 baud tick and deserialises one frame: start bit, N_DATA data bits (LSB first), optional parity bit, stop bit(s).
- Presents the received word on o_rx_data and pulses o_rx_done for one clock; that pulse is the interface's FIFO write strobe.

Parameters:
- N_DATA, 8, data bits per frame.
- PARITY_CHECK, 0, 0 = no parity bit; 1 = one parity bit received after the data bits and stored as MSB of o_rx_data.
- N_TICKS, 16, baud ticks per bit (oversampling ratio); must be even and >= 4.
- N_STOP_TICKS, 16, baud ticks spent in the stop bit (16 = 1 stop bit, 32 = 2 stop bits).

Ports:
- i_clk  in  1  system clock, all state on rising edge.
- i_rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_tick  in  1  single-cycle baud tick, N_TICKS per bit period.
- i_rx  in  1  serial line, idle high.
- o_rx_data  out  N_DATA+PARITY_CHECK  received word; parity bit (if any) at MSB, data bit 0 at LSB.
- o_rx_done  out  1  one-cycle pulse, word valid on o_rx_data.
- o_frame_err  out  1  stop-bit sample was 0 for the frame just completed; valid with o_rx_done.

Behaviour:
- Reset (i_rst=0, async): state=IDLE, tick counter=0, bit counter=0, shift reg=0, o_rx_data=0, o_rx_done=0, o_frame_err=0.
- Counters:
  - Tick counter s is clog2(max(N_TICKS, N_STOP_TICKS)) bits.
  - Bit counter n is clog2(N_DATA) bits.
  - Both use the shared clog2 include.
- IDLE:
  - i_rx==0 (sampled on any clock, tick not required) -> START, s=0.
- START: on i_tick:
  - s==N_TICKS/2-1: if i_rx==0 -> DATA, s=0, n=0; if i_rx==1 (glitch) -> IDLE, no output.
  - Else s++.
- DATA: on i_tick:
  - s==N_TICKS-1: s=0; shift i_rx into MSB of data shift reg (right shift, LSB-first line order).
  - If n==N_DATA-1 -> PARITY when PARITY_CHECK=1, else STOP; otherwise n++.
  - Else s++.
- PARITY (only when PARITY_CHECK=1): on i_tick with s==N_TICKS-1, capture i_rx as parity bit, s=0 -> STOP.
- Parity is not checked; the raw bit is passed up.
- STOP: on i_tick:
  - s==N_STOP_TICKS-1 -> IDLE, s=0.
  - Same edge: o_rx_data <= {parity, shift reg}, o_rx_done <= 1, o_frame_err <= ~i_rx.
  - Else s++.
- o_rx_done is high exactly one clock per completed frame; o_rx_data and o_frame_err hold until the next completion.
- A frame with a framing error still asserts o_rx_done; the word is delivered.
- Sampling lands mid-bit: START consumes N_TICKS/2 ticks, each data/parity bit consumes N_TICKS ticks.
- Latency: o_rx_done rises one clock after the tick that ends the stop-bit count.
- i_tick is ignored in IDLE. i_rx changes between ticks are ignored outside IDLE.
- i_rx held low continuously yields frame 0x00 with o_frame_err=1, then immediately re-enters START.
- Back-to-back frames: a START edge on the first clock after STOP->IDLE is accepted; no idle gap required.
- Reset mid-frame aborts: no o_rx_done, and the partial word is not loaded into o_rx_data.
- No backpressure; the downstream FIFO must accept every o_rx_done pulse.

Optional Feature:
- Macro: UART_RX_INPUT_SYNC_EN.
- Defined: i_rx passes through a 2-flop synchroniser (both flops reset to 1), and all logic uses the synchronised value. Start detection and all samples are delayed by 2 clocks; frame-to-done latency grows by 2 clocks.
- Undefined: i_rx is used directly; the line is assumed already synchronous.

Decomposition:
- Shared package/header holds:
  - State encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4 (NB_STATES=3).
  - clog2 function.
  - Default N_DATA / N_TICKS constants, shared with the TX side and the interface.
- One natural sub-module: uart_rx_sync (2-flop synchroniser, async active-low reset to 1), instantiated only under UART_RX_INPUT_SYNC_EN.
- Baud tick generator is a separate existing block, not part of this one.

Test Plan:
- Stimulus for all tests: i_tick every 4 clocks, defaults.
  - Frame 0x55 with stop=1 -> single o_rx_done pulse, o_rx_data=0x55, o_frame_err=0.
  - Frame 0xA3 with stop=0 -> o_rx_done pulse, o_rx_data=0xA3, o_frame_err=1.
- i_rx low for 5 ticks then high (glitch) -> return to IDLE, no o_rx_done, o_rx_data unchanged.
- Three back-to-back frames 0x01, 0xFF, 0x80 with no idle gap -> three pulses, data in order, none lost.
- PARITY_CHECK=1, frame 0x0F with parity bit 1 -> o_rx_data=9'h10F.
- i_rst low mid-DATA of frame 0x3C, then frame 0x42 -> no pulse for 0x3C, o_rx_data=0x42, all outputs 0 during reset.
